instruction_fetch: RTL and testbench

IF stage of the MIPS pipeline. Holds the instruction memory and computes the next PC. Drives the enable and next-address inputs of the pc register and consumes its current value. Owns the IF/ID pipeline register and the fetch run/step/halt control used by the debug unit.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 36 +++
 rtl/instruction_fetch_memory.sv | 24 ++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the IF stage: halt opcode, default memory depth
// and the fetch control state encoding.
package instruction_fetch_pkg;

   localparam logic [31:0] HALT_CODE  = 32'hFFFF_FFFF;
   localparam int          IMEM_DEPTH = 256;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_STEP = 2'd2,
      FETCH_HALT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle between the IF stage and its surroundings: pc register, hazard/branch
// sources, debug unit and the ID stage.
interface instruction_fetch_if #(
   parameter int NB_ADDR = 32,
   parameter int NB_INST = 32
);
   logic [NB_ADDR-1:0] pc_addr_i;
   logic [NB_ADDR-1:0] next_addr_o;
   logic               pc_enable_o;
   logic               branch_taken_i;
   logic [NB_ADDR-1:0] branch_addr_i;
   logic               jump_i;
   logic [NB_ADDR-1:0] jump_addr_i;
   logic               stall_i;
   logic               run_i;
   logic               step_i;
   logic               load_en_i;
   logic [NB_ADDR-1:0] load_addr_i;
   logic [NB_INST-1:0] load_data_i;
   logic [NB_INST-1:0] instruction_o;
   logic [NB_ADDR-1:0] pc_plus4_o;
   logic               valid_o;
   logic               halted_o;

   modport master (
      input  pc_addr_i, branch_taken_i, branch_addr_i, jump_i, jump_addr_i,
             stall_i, run_i, step_i, load_en_i, load_addr_i, load_data_i,
      output next_addr_o, pc_enable_o, instruction_o, pc_plus4_o, valid_o, halted_o
   );

   modport slave (
      output pc_addr_i, branch_taken_i, branch_addr_i, jump_i, jump_addr_i,
             stall_i, run_i, step_i, load_en_i, load_addr_i, load_data_i,
      input  next_addr_o, pc_enable_o, instruction_o, pc_plus4_o, valid_o, halted_o
   );
endinterface

// File: rtl/instruction_fetch_memory.sv
// Instruction memory: one synchronous write port for the debug loader and one
// combinational read port for fetch. Contents are not reset.
module instruction_memory #(
   parameter  int NB_INST   = 32,
   parameter  int MEM_DEPTH = 256,
   localparam int NB_INDEX  = $clog2(MEM_DEPTH)
) (
   input  logic                clock,
   input  logic                write_en,
   input  logic [NB_INDEX-1:0] write_index,
   input  logic [NB_INST-1:0]  write_data,
   input  logic [NB_INDEX-1:0] read_index,
   output logic [NB_INST-1:0]  read_data
);

   logic [NB_INST-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clock) begin
      if (write_en) mem[write_index] <= write_data;
   end

   assign read_data = mem[read_index];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: next-PC selection, instruction memory, IF/ID register and the
// run/step/halt fetch control driven by the debug unit.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                 NB_ADDR   = 32,
   parameter int                 NB_INST   = 32,
   parameter int                 MEM_DEPTH = IMEM_DEPTH,
   parameter logic [NB_INST-1:0] HALT_CODE = instruction_fetch_pkg::HALT_CODE
) (
   input logic                 clock_i,
   input logic                 reset_i,
   instruction_fetch_if.master bus
);

   localparam int NB_INDEX = $clog2(MEM_DEPTH);

   fetch_state_t       state;
   logic               fetch_go;
   logic               flush;
   logic               load_word;
   logic               hit_halt;
   logic [NB_ADDR-1:0] pc4;
   logic [NB_INST-1:0] mem_word;
   logic               unused_addr_bits;

   // Byte-offset bits and bits above the memory depth are dropped, so addresses wrap.
   assign unused_addr_bits = ^{bus.load_addr_i[NB_ADDR-1:NB_INDEX+2], bus.load_addr_i[1:0]};

   instruction_memory #(
      .NB_INST   (NB_INST),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_imem (
      .clock       (clock_i),
      .write_en    (bus.load_en_i && (state == FETCH_IDLE)),
      .write_index (bus.load_addr_i[NB_INDEX+1:2]),
      .write_data  (bus.load_data_i),
      .read_index  (bus.pc_addr_i[NB_INDEX+1:2]),
      .read_data   (mem_word)
   );

   assign pc4 = bus.pc_addr_i + NB_ADDR'(4);

   always_comb begin
      fetch_go = 1'b0;
      unique case (state)
         FETCH_RUN:  fetch_go = 1'b1;
         FETCH_STEP: fetch_go = bus.step_i;
         default:    fetch_go = 1'b0;
      endcase
   end

   always_comb begin
      bus.next_addr_o = pc4;
      if (bus.branch_taken_i)  bus.next_addr_o = bus.branch_addr_i;
      else if (bus.jump_i)     bus.next_addr_o = bus.jump_addr_i;
   end

   // A resolved branch must redirect even under a stall; a jump waits for the stall to clear.
   assign bus.pc_enable_o = fetch_go & (bus.branch_taken_i | ~bus.stall_i);

   assign flush     = bus.branch_taken_i | (bus.jump_i & ~bus.stall_i & fetch_go);
   assign load_word = fetch_go & ~bus.branch_taken_i & ~bus.jump_i & ~bus.stall_i;
   assign hit_halt  = load_word & (mem_word == HALT_CODE);

   // The HALT word itself is latched as a valid instruction so the pipeline drains behind it.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state             <= FETCH_IDLE;
         bus.instruction_o <= '0;
         bus.pc_plus4_o    <= '0;
         bus.valid_o       <= 1'b0;
         bus.halted_o      <= 1'b0;
      end else begin
         unique case (state)
            FETCH_IDLE: begin
               if (bus.run_i)       state <= FETCH_RUN;
               else if (bus.step_i) state <= FETCH_STEP;
            end
            FETCH_RUN, FETCH_STEP: begin
               if (flush) begin
                  bus.instruction_o <= '0;
                  bus.pc_plus4_o    <= '0;
                  bus.valid_o       <= 1'b0;
               end else if (load_word) begin
                  bus.instruction_o <= mem_word;
                  bus.pc_plus4_o    <= pc4;
                  bus.valid_o       <= 1'b1;
               end
               if (hit_halt) begin
                  state        <= FETCH_HALT;
                  bus.halted_o <= 1'b1;
               end else if ((state == FETCH_STEP) && bus.run_i) begin
                  state <= FETCH_RUN;
               end
            end
            FETCH_HALT: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic compared against a behavioural fetch model kept here.
module tb_instruction_fetch;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic [31:0] pc_q;
   int          n_asserts  = 0;
   int          n_failures = 0;

   // Reference model state
   logic [31:0] m_mem [256];
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_halted, m_run, m_step;
   logic [31:0] held_instr, held_pc4, w;

   always #5 clock_i = ~clock_i;

   instruction_fetch_if #(.NB_ADDR(32), .NB_INST(32)) bus ();

   instruction_fetch #(
      .NB_ADDR   (32),
      .NB_INST   (32),
      .MEM_DEPTH (256),
      .HALT_CODE (32'hFFFF_FFFF)
   ) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus.master)
   );

   // External pc register, reset by the same reset as the stage
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)              pc_q <= 32'h0;
      else if (bus.pc_enable_o) pc_q <= bus.next_addr_o;
   end
   assign bus.pc_addr_i = pc_q;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_failures++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_failures++;
         $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_output();
      check_word("instruction", bus.instruction_o, m_instr);
      check_word("pc_plus4",    bus.pc_plus4_o,    m_pc4);
      check_bit ("valid",       bus.valid_o,       m_valid);
      check_bit ("halted",      bus.halted_o,      m_halted);
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance model and DUT.
   task automatic apply_stimulus(input logic run, input logic step, input logic br,
                                 input logic [31:0] ba, input logic jp, input logic [31:0] ja,
                                 input logic st, input logic le, input logic [31:0] la,
                                 input logic [31:0] ld);
      logic        go, en, idle;
      logic [31:0] nxt, word;
      bus.run_i = run;  bus.step_i = step;  bus.branch_taken_i = br; bus.branch_addr_i = ba;
      bus.jump_i = jp;  bus.jump_addr_i = ja; bus.stall_i = st;
      bus.load_en_i = le; bus.load_addr_i = la; bus.load_data_i = ld;
      #1;
      go  = m_run | (m_step & step);
      nxt = br ? ba : (jp ? ja : m_pc + 32'd4);
      en  = go & (br | ~st);
      check_word("pc_reg",    pc_q,            m_pc);
      check_word("next_addr", bus.next_addr_o, nxt);
      check_bit ("pc_enable", bus.pc_enable_o, en);
      idle = !m_run && !m_step && !m_halted;
      if (m_run || m_step) begin
         if (br || (go && jp && !st)) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         end else if (go && !st) begin
            word = m_mem[m_pc[9:2]];
            m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            if (word == HALT) begin
               m_halted = 1'b1; m_run = 1'b0; m_step = 1'b0;
            end
         end
      end
      if (idle) begin
         if (le) m_mem[la[9:2]] = ld;
         if (run)       m_run  = 1'b1;
         else if (step) m_step = 1'b1;
      end else if (m_step && run) begin
         m_step = 1'b0; m_run = 1'b1;
      end
      if (en) m_pc = nxt;
      @(posedge clock_i);
      #1;
      check_output();
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, a, d);
   endtask

   task automatic run_cycle(input logic br, input logic [31:0] ba, input logic jp,
                            input logic [31:0] ja, input logic st);
      apply_stimulus(1'b0, 1'b0, br, ba, jp, ja, st, 1'b0, 32'h0, 32'h0);
   endtask

   // Reset asserted between clock edges; outputs must clear without a clock.
   task automatic do_reset();
      bus.run_i = 1'b0; bus.step_i = 1'b0; bus.branch_taken_i = 1'b0; bus.branch_addr_i = 32'h0;
      bus.jump_i = 1'b0; bus.jump_addr_i = 32'h0; bus.stall_i = 1'b0;
      bus.load_en_i = 1'b0; bus.load_addr_i = 32'h0; bus.load_data_i = 32'h0;
      reset_i = 1'b1;
      #1;
      check_word("rst_instruction", bus.instruction_o, 32'h0);
      check_word("rst_pc_plus4",    bus.pc_plus4_o,    32'h0);
      check_bit ("rst_valid",       bus.valid_o,       1'b0);
      check_bit ("rst_halted",      bus.halted_o,      1'b0);
      check_bit ("rst_pc_enable",   bus.pc_enable_o,   1'b0);
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_run = 1'b0; m_step = 1'b0;
      #2;
      reset_i = 1'b0;
      @(posedge clock_i);
      #1;
   endtask

   initial begin
      do_reset();

      // Fill the whole memory with non-HALT words, then the load-and-run program
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         if (w == HALT) w = 32'h0;
         load_word(i * 4, w);
      end
      load_word(32'h0, 32'h2001_0005);
      load_word(32'h4, 32'h2002_0007);
      load_word(32'h8, HALT);

      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_bit("run_pulse_no_fetch", bus.valid_o, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("prog_instr0", bus.instruction_o, 32'h2001_0005);
      check_word("prog_pc4_0",  bus.pc_plus4_o,    32'h4);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("prog_instr1", bus.instruction_o, 32'h2002_0007);
      check_word("prog_pc4_1",  bus.pc_plus4_o,    32'h8);
      check_bit ("prog_not_halted_yet", bus.halted_o, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("prog_halt_word", bus.instruction_o, HALT);
      check_word("prog_halt_pc4",  bus.pc_plus4_o,    32'hC);
      check_bit ("prog_halt_valid", bus.valid_o,      1'b1);
      run_cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
      check_bit ("halted_sticky", bus.halted_o, 1'b1);
      check_word("halted_holds",  bus.instruction_o, HALT);
      check_word("halted_pc",     pc_q, 32'hC);
      run_cycle(1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
      check_bit ("halted_no_enable", bus.pc_enable_o, 1'b0);

      // Second program: overwrite the HALT, and write index 0 through a wrapped address
      do_reset();
      w = $urandom;
      if (w == HALT) w = 32'h1;
      load_word(32'h408, w);
      load_word(32'h400, 32'hA5A5_0001);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("wrap_write_idx0", bus.instruction_o, 32'hA5A5_0001);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("pc_before_branch", pc_q, 32'h10);

      // Branch flush at PC 0x10
      run_cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
      check_bit ("branch_bubble_valid", bus.valid_o, 1'b0);
      check_word("branch_bubble_instr", bus.instruction_o, 32'h0);
      check_word("branch_target_pc", pc_q, 32'h40);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("after_branch_pc4", bus.pc_plus4_o, 32'h44);

      // Stalls hold IF/ID and pc; a jump does not beat a stall, a branch does
      held_instr = bus.instruction_o;
      held_pc4   = bus.pc_plus4_o;
      for (int i = 0; i < 2; i++) begin
         run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
         check_word("stall_hold_instr", bus.instruction_o, held_instr);
         check_word("stall_hold_pc4",   bus.pc_plus4_o,    held_pc4);
      end
      run_cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
      check_word("stall_jump_hold", bus.instruction_o, held_instr);
      check_word("stall_jump_pc",   pc_q, 32'h44);
      run_cycle(1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
      check_bit ("stall_branch_bubble", bus.valid_o, 1'b0);
      check_word("stall_branch_pc",     pc_q, 32'h80);

      // Jump to the top of the address space; pc+4 wraps to zero
      run_cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("pc4_wrap", bus.pc_plus4_o, 32'h0);

      // Random traffic in RUN
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(1'b0, ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC,
                        ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC,
                        ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 7) == 0), $urandom, $urandom);
      end

      // Mid-run reset, then confirm the write attempted in RUN was dropped
      do_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_word("run_load_ignored", bus.instruction_o, 32'hA5A5_0001);

      // Step mode: the entering pulse does not fetch; each later pulse fetches once
      do_reset();
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_word("step_enter_pc", pc_q, 32'h0);
      check_bit ("step_enter_valid", bus.valid_o, 1'b0);
      for (int p = 0; p < 3; p++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
         for (int k = 0; k < 5; k++) idle_cycle();
      end
      check_word("step_pc_after3",  pc_q, 32'hC);
      check_word("step_pc4_after3", bus.pc_plus4_o, 32'hC);

      // Random traffic in STEP, finishing with a switch to RUN
      for (int i = 0; i < 150; i++) begin
         apply_stimulus(1'b0, ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC,
                        ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC,
                        ($urandom_range(0, 3) == 0), 1'b0, 32'h0, 32'h0);
      end
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
      $finish;
   end

endmodule
